// File: rtl/exc_ctrl.sv
// Exception control stage for the single-cycle MIPS datapath: squashes faulting
// instructions, records EPC/Cause and redirects the PC. Optional EXC_EXT_INT_EN adds ext_int.
module exc_ctrl #(
    parameter int              PC_W        = 32,
    parameter logic [PC_W-1:0] VECTOR_ADDR = PC_W'(32'h0000_0180)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_int,
    input  logic            int_cause,
    input  logic [PC_W-1:0] pc,
    input  logic            eret,
`ifdef EXC_EXT_INT_EN
    input  logic            ext_int,
`endif
    output logic            flush,
    output logic            pc_redirect,
    output logic [PC_W-1:0] pc_target,
    output logic [PC_W-1:0] epc,
    output logic [4:0]      cause,
    output logic            in_handler,
    output logic            double_fault
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_TAKE    = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RETURN  = 2'd3
    } state_t;

    localparam logic [4:0] CAUSE_OV  = 5'd12;
    localparam logic [4:0] CAUSE_RI  = 5'd10;
    localparam logic [4:0] CAUSE_INT = 5'd0;

    state_t          state_q, state_d;
    logic [PC_W-1:0] epc_q, epc_d;
    logic [4:0]      cause_q, cause_d;
    logic            dfault_q, dfault_d;
    logic            in_handler_q, in_handler_d;
    logic            redirect_q, redirect_d;
    logic [PC_W-1:0] target_q, target_d;
    logic            flush_s;
    logic            ext_req_s;

`ifdef EXC_EXT_INT_EN
    logic ext_meta_q, ext_sync_q;

    // Two-flop synchronizer for the asynchronous interrupt level.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_meta_q <= 1'b0;
            ext_sync_q <= 1'b0;
        end else begin
            ext_meta_q <= ext_int;
            ext_sync_q <= ext_meta_q;
        end
    end

    assign ext_req_s = ext_sync_q;
`else
    assign ext_req_s = 1'b0;
`endif

    // Next-state, architectural record updates and squash decision.
    always_comb begin
        state_d  = state_q;
        epc_d    = epc_q;
        cause_d  = cause_q;
        dfault_d = dfault_q;
        flush_s  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (cpu_int) begin
                    flush_s = 1'b1;
                    epc_d   = pc;
                    cause_d = int_cause ? CAUSE_OV : CAUSE_RI;
                    state_d = ST_TAKE;
                end else if (ext_req_s) begin
                    flush_s = 1'b1;
                    epc_d   = pc;
                    cause_d = CAUSE_INT;
                    state_d = ST_TAKE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_TAKE: begin
                flush_s = 1'b1;
                state_d = ST_HANDLER;
            end
            ST_HANDLER: begin
                if (cpu_int) begin
                    flush_s  = 1'b1;
                    dfault_d = 1'b1;
                end else begin
                    flush_s = 1'b0;
                end
                if (eret) begin
                    state_d = ST_RETURN;
                end else begin
                    state_d = ST_HANDLER;
                end
            end
            ST_RETURN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Redirect/EXL outputs are registered from the state being entered.
        redirect_d   = (state_d == ST_TAKE) || (state_d == ST_RETURN);
        in_handler_d = (state_d == ST_TAKE) || (state_d == ST_HANDLER);
        case (state_d)
            ST_TAKE:   target_d = VECTOR_ADDR;
            ST_RETURN: target_d = epc_d + PC_W'(4);
            default:   target_d = '0;
        endcase
    end

    // State and registered output update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            epc_q        <= '0;
            cause_q      <= 5'd0;
            dfault_q     <= 1'b0;
            in_handler_q <= 1'b0;
            redirect_q   <= 1'b0;
            target_q     <= '0;
        end else begin
            state_q      <= state_d;
            epc_q        <= epc_d;
            cause_q      <= cause_d;
            dfault_q     <= dfault_d;
            in_handler_q <= in_handler_d;
            redirect_q   <= redirect_d;
            target_q     <= target_d;
        end
    end

    assign flush        = flush_s & ~rst;
    assign pc_redirect  = redirect_q;
    assign pc_target    = target_q;
    assign epc          = epc_q;
    assign cause        = cause_q;
    assign in_handler   = in_handler_q;
    assign double_fault = dfault_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl; ext_int scenarios build only with EXC_EXT_INT_EN.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst, cpu_int, int_cause, eret;
    logic [31:0] pc;
`ifdef EXC_EXT_INT_EN
    logic        ext_int;
`endif
    logic        flush, pc_redirect, in_handler, double_fault;
    logic [31:0] pc_target, epc;
    logic [4:0]  cause;

    int total = 0;
    int bad   = 0;

    exc_ctrl dut (
        .clk(clk), .rst(rst), .cpu_int(cpu_int), .int_cause(int_cause),
        .pc(pc), .eret(eret),
`ifdef EXC_EXT_INT_EN
        .ext_int(ext_int),
`endif
        .flush(flush), .pc_redirect(pc_redirect), .pc_target(pc_target),
        .epc(epc), .cause(cause), .in_handler(in_handler), .double_fault(double_fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_int = 1'b0; int_cause = 1'b0; eret = 1'b0; pc = 32'h0;
`ifdef EXC_EXT_INT_EN
        ext_int = 1'b0;
`endif
        tick(); tick();
        rst = 1'b0;
        #1;
        total++; if (pc_redirect !== 1'b0) begin bad++; $display("FAIL rst_redirect got=%0h exp=0", pc_redirect); end
        total++; if (pc_target !== 32'h0) begin bad++; $display("FAIL rst_target got=%0h exp=0", pc_target); end
        total++; if (epc !== 32'h0) begin bad++; $display("FAIL rst_epc got=%0h exp=0", epc); end
        total++; if (cause !== 5'd0) begin bad++; $display("FAIL rst_cause got=%0d exp=0", cause); end
        total++; if (in_handler !== 1'b0 || double_fault !== 1'b0) begin bad++; $display("FAIL rst_flags got=%0b%0b exp=00", in_handler, double_fault); end
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL rst_flush got=%0h exp=0", flush); end
    endtask

    task automatic test_overflow();
        pc = 32'h0040_0010; cpu_int = 1'b1; int_cause = 1'b1;
        #1;
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL ov_flush got=%0h exp=1", flush); end
        tick();
        // TAKE: a second request here must be ignored
        pc = 32'h0000_0999; int_cause = 1'b0;
        #1;
        total++; if (pc_redirect !== 1'b1) begin bad++; $display("FAIL ov_redirect got=%0h exp=1", pc_redirect); end
        total++; if (pc_target !== 32'h180) begin bad++; $display("FAIL ov_target got=%0h exp=180", pc_target); end
        total++; if (epc !== 32'h0040_0010) begin bad++; $display("FAIL ov_epc got=%0h exp=400010", epc); end
        total++; if (cause !== 5'd12) begin bad++; $display("FAIL ov_cause got=%0d exp=12", cause); end
        total++; if (in_handler !== 1'b1) begin bad++; $display("FAIL ov_inh got=%0h exp=1", in_handler); end
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL take_flush got=%0h exp=1", flush); end
        tick();
        cpu_int = 1'b0;
        #1;
        total++; if (pc_redirect !== 1'b0 || pc_target !== 32'h0) begin bad++; $display("FAIL hnd_redirect got=%0h/%0h exp=0/0", pc_redirect, pc_target); end
        total++; if (epc !== 32'h0040_0010 || cause !== 5'd12 || double_fault !== 1'b0) begin bad++; $display("FAIL take_ignore got=%0h/%0d/%0h exp=400010/12/0", epc, cause, double_fault); end
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL hnd_flush got=%0h exp=0", flush); end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        #1;
        total++; if (pc_redirect !== 1'b1 || pc_target !== 32'h0040_0014) begin bad++; $display("FAIL ov_ret got=%0h/%0h exp=1/400014", pc_redirect, pc_target); end
        total++; if (in_handler !== 1'b0 || flush !== 1'b0) begin bad++; $display("FAIL ov_ret_flags got=%0h/%0h exp=0/0", in_handler, flush); end
        tick();
        total++; if (pc_redirect !== 1'b0) begin bad++; $display("FAIL ov_ret_once got=%0h exp=0", pc_redirect); end
    endtask

    task automatic test_illegal_return();
        pc = 32'h100; cpu_int = 1'b1; int_cause = 1'b0;
        tick();
        cpu_int = 1'b0;
        #1;
        total++; if (cause !== 5'd10 || epc !== 32'h100) begin bad++; $display("FAIL ri_cause got=%0d/%0h exp=10/100", cause, epc); end
        tick(); tick();
        eret = 1'b1;
        #1;
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL ri_eret_flush got=%0h exp=0", flush); end
        tick();
        eret = 1'b0;
        #1;
        total++; if (pc_redirect !== 1'b1 || pc_target !== 32'h104 || in_handler !== 1'b0) begin bad++; $display("FAIL ri_ret got=%0h/%0h/%0h exp=1/104/0", pc_redirect, pc_target, in_handler); end
        tick();
    endtask

    task automatic test_double_fault();
        pc = 32'h300; cpu_int = 1'b1; int_cause = 1'b1;
        tick();
        cpu_int = 1'b0;
        tick();
        pc = 32'h184; cpu_int = 1'b1; int_cause = 1'b0;
        #1;
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL df_flush got=%0h exp=1", flush); end
        tick();
        cpu_int = 1'b0;
        #1;
        total++; if (double_fault !== 1'b1) begin bad++; $display("FAIL df_set got=%0h exp=1", double_fault); end
        total++; if (epc !== 32'h300 || cause !== 5'd12) begin bad++; $display("FAIL df_keep got=%0h/%0d exp=300/12", epc, cause); end
        total++; if (pc_redirect !== 1'b0 || in_handler !== 1'b1) begin bad++; $display("FAIL df_stay got=%0h/%0h exp=0/1", pc_redirect, in_handler); end
        // simultaneous fault and eret: both act
        cpu_int = 1'b1; eret = 1'b1;
        #1;
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL df_eret_flush got=%0h exp=1", flush); end
        tick();
        cpu_int = 1'b0; eret = 1'b0;
        #1;
        total++; if (pc_redirect !== 1'b1 || pc_target !== 32'h304) begin bad++; $display("FAIL df_eret_ret got=%0h/%0h exp=1/304", pc_redirect, pc_target); end
        tick(); tick();
        total++; if (double_fault !== 1'b1) begin bad++; $display("FAIL df_sticky got=%0h exp=1", double_fault); end
    endtask

    task automatic test_wrap_stray_eret();
        eret = 1'b1; pc = 32'h500;
        #1;
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL stray_flush got=%0h exp=0", flush); end
        tick();
        eret = 1'b0;
        #1;
        total++; if (pc_redirect !== 1'b0 || in_handler !== 1'b0) begin bad++; $display("FAIL stray_redirect got=%0h/%0h exp=0/0", pc_redirect, in_handler); end
        pc = 32'hFFFF_FFFC; cpu_int = 1'b1; int_cause = 1'b1;
        tick();
        cpu_int = 1'b0;
        tick();
        eret = 1'b1;
        tick();
        eret = 1'b0;
        #1;
        total++; if (pc_redirect !== 1'b1 || pc_target !== 32'h0) begin bad++; $display("FAIL wrap_target got=%0h/%0h exp=1/0", pc_redirect, pc_target); end
        tick();
    endtask

    task automatic test_reset_mid();
        pc = 32'h700; cpu_int = 1'b1; int_cause = 1'b1;
        tick();
        cpu_int = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++; if (pc_redirect !== 1'b0 || in_handler !== 1'b0) begin bad++; $display("FAIL mid_rst_flags got=%0h/%0h exp=0/0", pc_redirect, in_handler); end
        total++; if (epc !== 32'h0 || cause !== 5'd0 || double_fault !== 1'b0) begin bad++; $display("FAIL mid_rst_regs got=%0h/%0d/%0h exp=0/0/0", epc, cause, double_fault); end
        tick();
        total++; if (pc_redirect !== 1'b0 || pc_target !== 32'h0) begin bad++; $display("FAIL mid_rst_drop got=%0h/%0h exp=0/0", pc_redirect, pc_target); end
    endtask

`ifdef EXC_EXT_INT_EN
    task automatic test_ext_int();
        pc = 32'h200; ext_int = 1'b1;
        tick(); tick();
        cpu_int = 1'b1; int_cause = 1'b1;
        #1;
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL ext_pri_flush got=%0h exp=1", flush); end
        tick();
        cpu_int = 1'b0; ext_int = 1'b0;
        #1;
        total++; if (cause !== 5'd12) begin bad++; $display("FAIL ext_pri_cause got=%0d exp=12", cause); end
        tick(); eret = 1'b1; tick(); eret = 1'b0; tick(); tick();
        pc = 32'h200; ext_int = 1'b1;
        #1;
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL ext_early got=%0h exp=0", flush); end
        tick(); tick();
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL ext_flush got=%0h exp=1", flush); end
        tick();
        ext_int = 1'b0;
        #1;
        total++; if (cause !== 5'd0 || epc !== 32'h200 || pc_redirect !== 1'b1) begin bad++; $display("FAIL ext_take got=%0d/%0h/%0h exp=0/200/1", cause, epc, pc_redirect); end
        tick(); eret = 1'b1; tick(); eret = 1'b0;
        #1;
        total++; if (pc_target !== 32'h204) begin bad++; $display("FAIL ext_ret got=%0h exp=204", pc_target); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_overflow();
        test_illegal_return();
        test_double_fault();
        test_wrap_stray_eret();
        test_reset_mid();
`ifdef EXC_EXT_INT_EN
        test_ext_int();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
